// File: rtl/datapath_controller.sv
// ---------------------------------------------------------------------------
// datapath_controller
//   Instruction register, decoder and control FSM for a register-file/ALU
//   datapath. One 16-bit instruction is latched into IR while idle, then
//   executed over several cycles by issuing register-file read/write
//   controls, operand latch strobes, ALU operation and shifter codes.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   s         start execution of IR (only looked at while idle)
//   load      IR load enable (only honoured while idle)
//   in        instruction word
//   w         1 while idle and ready for s
//   ALUop     00 add, 01 sub, 10 and, 11 not-B
//   shift     shifter code for the datapath B path
//   readnum   register-file read index
//   writenum  register-file write index
//   write     register-file write enable
//   loada/b/c latch A, B, C registers
//   loads     latch status flags
//   asel      1 = A operand forced to zero
//   bsel      1 = B operand taken from sximm5
//   vsel      write-back source: 00 C, 10 sximm8
//   sximm8    sign-extended IR[7:0]
//   sximm5    sign-extended IR[4:0]
// ---------------------------------------------------------------------------
module datapath_controller #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic             w,
  output logic [1:0]       ALUop,
  output logic [1:0]       shift,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic [WIDTH-1:0] sximm8,
  output logic [WIDTH-1:0] sximm5
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_EXEC      = 3'd5,
    ST_WRITE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  // Instruction fields
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  // Instruction classes
  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = is_alu && (op == 2'b01);
  assign is_mvn     = is_alu && (op == 2'b11);

  // IR only accepts a new word while idle; a simultaneous s moves to
  // DECODE on the same edge, so DECODE sees the freshly loaded word.
  always_comb begin
    ir_d = ir_q;
    if ((state_q == ST_WAIT) && load)
      ir_d = in;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:      if (s) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_mov_imm)                 state_d = ST_WRITE_IMM;
        else if (is_alu && !is_mvn)     state_d = ST_GET_A;  // ADD, CMP, AND
        else if (is_mov_reg || is_mvn)  state_d = ST_GET_B;  // single-operand ops
        else                            state_d = ST_WAIT;   // illegal encoding
      end
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_EXEC;
      ST_EXEC:      state_d = is_cmp ? ST_WAIT : ST_WRITE;
      ST_WRITE:     state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // Output logic: Moore strobes qualified by IR fields
  always_comb begin
    w        = 1'b0;
    ALUop    = 2'b00;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    case (state_q)
      ST_WAIT: w = 1'b1;
      ST_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      ST_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      ST_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      ST_EXEC: begin
        // MOV reg computes 0 + shifted Rm through the adder
        ALUop = is_mov_reg ? 2'b00 : op;
        asel  = is_mov_reg;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      ST_WRITE: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  // The shift field overlaps the immediate of MOV imm, so it is masked there
  assign shift  = is_mov_imm ? 2'b00 : sh;
  assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

endmodule

// File: tb/tb_datapath_controller.sv
module tb_datapath_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in_w;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  ALUop, shift, vsel;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8, sximm5;

  int errors = 0;
  int checks = 0;

  // {write, loada, loadb, loadc, loads, asel, bsel}
  wire [6:0] strobes = {write, loada, loadb, loadc, loads, asel, bsel};

  datapath_controller #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in_w),
    .w(w), .ALUop(ALUop), .shift(shift), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load an instruction while idle, then pulse s; returns sampled in DECODE
  task automatic start_instr(input logic [15:0] instr);
    load = 1'b1; in_w = instr;
    tick();
    load = 1'b0; s = 1'b1;
    tick();
    s = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; s = 1'b0; load = 1'b0; in_w = 16'h0;
    tick();
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL reset_w got=%b exp=1", w); end
    checks++; if (strobes !== 7'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0000000", strobes); end
    checks++; if (ALUop !== 2'b00) begin errors++; $display("FAIL reset_aluop got=%b exp=00", ALUop); end
    checks++; if (vsel !== 2'b00) begin errors++; $display("FAIL reset_vsel got=%b exp=00", vsel); end
    checks++; if (sximm8 !== 16'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0000", sximm8); end
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_mov_imm();
    start_instr(16'hD007);
    checks++; if ({w, strobes} !== 8'b0) begin errors++; $display("FAIL movi_decode got=%b exp=00000000", {w, strobes}); end
    tick();
    checks++; if (writenum !== 3'd0) begin errors++; $display("FAIL movi_writenum got=%0d exp=0", writenum); end
    checks++; if (vsel !== 2'b10) begin errors++; $display("FAIL movi_vsel got=%b exp=10", vsel); end
    checks++; if (sximm8 !== 16'h0007) begin errors++; $display("FAIL movi_sximm8 got=%h exp=0007", sximm8); end
    checks++; if (strobes !== 7'b1000000) begin errors++; $display("FAIL movi_strobes got=%b exp=1000000", strobes); end
    tick();
    checks++; if ({w, strobes} !== 8'b10000000) begin errors++; $display("FAIL movi_done got=%b exp=10000000", {w, strobes}); end
    $display("test_mov_imm done");
  endtask

  // Load and s in the same cycle: DECODE must see the new word
  task automatic test_mov_imm_neg();
    load = 1'b1; s = 1'b1; in_w = 16'hD2FF;
    tick();
    load = 1'b0; s = 1'b0;
    checks++; if (sximm8 !== 16'hFFFF) begin errors++; $display("FAIL movn_sximm8 got=%h exp=ffff", sximm8); end
    checks++; if (sximm5 !== 16'hFFFF) begin errors++; $display("FAIL movn_sximm5 got=%h exp=ffff", sximm5); end
    checks++; if (shift !== 2'b00) begin errors++; $display("FAIL movn_shift got=%b exp=00", shift); end
    tick();
    checks++; if (writenum !== 3'd2) begin errors++; $display("FAIL movn_writenum got=%0d exp=2", writenum); end
    checks++; if (strobes !== 7'b1000000) begin errors++; $display("FAIL movn_strobes got=%b exp=1000000", strobes); end
    tick();
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL movn_done got=%b exp=1", w); end
    $display("test_mov_imm_neg done");
  endtask

  task automatic test_add();
    start_instr(16'hA0A9);
    checks++; if ({w, strobes} !== 8'b0) begin errors++; $display("FAIL add_decode got=%b exp=00000000", {w, strobes}); end
    checks++; if (sximm5 !== 16'h0009) begin errors++; $display("FAIL add_sximm5 got=%h exp=0009", sximm5); end
    tick();
    checks++; if ({readnum, strobes} !== {3'd0, 7'b0100000}) begin errors++; $display("FAIL add_get_a got=%0d/%b exp=0/0100000", readnum, strobes); end
    tick();
    checks++; if ({readnum, strobes} !== {3'd1, 7'b0010000}) begin errors++; $display("FAIL add_get_b got=%0d/%b exp=1/0010000", readnum, strobes); end
    checks++; if (shift !== 2'b01) begin errors++; $display("FAIL add_shift got=%b exp=01", shift); end
    tick();
    checks++; if ({ALUop, strobes} !== {2'b00, 7'b0001000}) begin errors++; $display("FAIL add_exec got=%b/%b exp=00/0001000", ALUop, strobes); end
    tick();
    checks++; if ({writenum, vsel, strobes} !== {3'd5, 2'b00, 7'b1000000}) begin errors++; $display("FAIL add_write got=%0d/%b/%b exp=5/00/1000000", writenum, vsel, strobes); end
    tick();
    checks++; if ({w, strobes} !== 8'b10000000) begin errors++; $display("FAIL add_done got=%b exp=10000000", {w, strobes}); end
    $display("test_add done");
  endtask

  // AND R2,R3,R2 sh=01: checks Rn path, ALUop=10 and the 5-cycle busy time
  task automatic test_and();
    int lowcnt = 0;
    start_instr(16'hB34A);
    tick();
    checks++; if ({readnum, loada} !== {3'd3, 1'b1}) begin errors++; $display("FAIL and_get_a got=%0d/%b exp=3/1", readnum, loada); end
    tick(); tick();
    checks++; if ({ALUop, loadc} !== {2'b10, 1'b1}) begin errors++; $display("FAIL and_exec got=%b/%b exp=10/1", ALUop, loadc); end
    tick();
    checks++; if (writenum !== 3'd2) begin errors++; $display("FAIL and_writenum got=%0d exp=2", writenum); end
    start_instr(16'hB34A);
    for (int i = 0; i < 20; i++) begin
      if (w) break;
      lowcnt++;
      tick();
    end
    checks++; if (lowcnt != 5) begin errors++; $display("FAIL and_busy got=%0d exp=5", lowcnt); end
    $display("test_and done");
  endtask

  task automatic test_cmp();
    int   lowcnt = 0;
    logic saw_write = 1'b0, saw_loads = 1'b0, saw_loadc = 1'b0;
    logic [1:0] op_at_loads = 2'bxx;
    start_instr(16'hA901);
    for (int i = 0; i < 20; i++) begin
      if (w) break;
      if (loads) begin saw_loads = 1'b1; op_at_loads = ALUop; end
      saw_write = saw_write | write;
      saw_loadc = saw_loadc | loadc;
      lowcnt++;
      tick();
    end
    checks++; if (lowcnt != 4) begin errors++; $display("FAIL cmp_busy got=%0d exp=4", lowcnt); end
    checks++; if (saw_loads !== 1'b1) begin errors++; $display("FAIL cmp_loads got=%b exp=1", saw_loads); end
    checks++; if (op_at_loads !== 2'b01) begin errors++; $display("FAIL cmp_aluop got=%b exp=01", op_at_loads); end
    checks++; if ({saw_write, saw_loadc} !== 2'b00) begin errors++; $display("FAIL cmp_no_write got=%b exp=00", {saw_write, saw_loadc}); end
    $display("test_cmp done");
  endtask

  task automatic test_mov_reg();
    start_instr(16'hC062);
    tick();
    checks++; if ({readnum, strobes} !== {3'd2, 7'b0010000}) begin errors++; $display("FAIL movr_get_b got=%0d/%b exp=2/0010000", readnum, strobes); end
    tick();
    checks++; if ({ALUop, strobes} !== {2'b00, 7'b0001010}) begin errors++; $display("FAIL movr_exec got=%b/%b exp=00/0001010", ALUop, strobes); end
    tick();
    checks++; if ({writenum, strobes} !== {3'd3, 7'b1000000}) begin errors++; $display("FAIL movr_write got=%0d/%b exp=3/1000000", writenum, strobes); end
    tick();
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL movr_done got=%b exp=1", w); end
    $display("test_mov_reg done");
  endtask

  task automatic test_mvn();
    start_instr(16'hB88C);
    tick();
    checks++; if ({readnum, shift, loadb} !== {3'd4, 2'b01, 1'b1}) begin errors++; $display("FAIL mvn_get_b got=%0d/%b/%b exp=4/01/1", readnum, shift, loadb); end
    tick();
    checks++; if ({ALUop, strobes} !== {2'b11, 7'b0001000}) begin errors++; $display("FAIL mvn_exec got=%b/%b exp=11/0001000", ALUop, strobes); end
    tick();
    checks++; if ({writenum, write} !== {3'd4, 1'b1}) begin errors++; $display("FAIL mvn_write got=%0d/%b exp=4/1", writenum, write); end
    tick();
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL mvn_done got=%b exp=1", w); end
    $display("test_mvn done");
  endtask

  task automatic test_illegal();
    logic [6:0] any = 7'b0;
    start_instr(16'hE000);
    checks++; if ({w, strobes} !== 8'b0) begin errors++; $display("FAIL ill_decode got=%b exp=00000000", {w, strobes}); end
    tick();
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL ill_back_wait got=%b exp=1", w); end
    for (int i = 0; i < 3; i++) begin
      any = any | strobes;
      tick();
    end
    checks++; if (any !== 7'b0) begin errors++; $display("FAIL ill_strobes got=%b exp=0000000", any); end
    $display("test_illegal done");
  endtask

  // load during GET_B must not disturb IR
  task automatic test_load_ignored();
    start_instr(16'hA0A9);
    tick(); tick();
    load = 1'b1; in_w = 16'hD2FF;
    tick();
    load = 1'b0;
    checks++; if (sximm8 !== 16'hFFA9) begin errors++; $display("FAIL ldign_ir got=%h exp=ffa9", sximm8); end
    checks++; if (strobes !== 7'b0001000) begin errors++; $display("FAIL ldign_exec got=%b exp=0001000", strobes); end
    tick();
    checks++; if (writenum !== 3'd5) begin errors++; $display("FAIL ldign_writenum got=%0d exp=5", writenum); end
    tick();
    $display("test_load_ignored done");
  endtask

  // s held high: exactly one idle cycle between instructions
  task automatic test_back_to_back();
    logic [4:0] exp_w = 5'b00100;
    logic [4:0] got_w;
    load = 1'b1; in_w = 16'hD007;
    tick();
    load = 1'b0; s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      got_w[i] = w;
    end
    s = 1'b0;
    checks++; if (got_w !== exp_w) begin errors++; $display("FAIL b2b_w_seq got=%b exp=%b", got_w, exp_w); end
    tick(); tick();
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", w); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    logic saw = 1'b0;
    start_instr(16'hA0A9);
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if ({w, strobes} !== 8'b10000000) begin errors++; $display("FAIL rstmid_state got=%b exp=10000000", {w, strobes}); end
    checks++; if (sximm8 !== 16'h0) begin errors++; $display("FAIL rstmid_ir got=%h exp=0000", sximm8); end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      saw = saw | write | loads | ~w;
      tick();
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_quiet got=%b exp=0", saw); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_mov_imm_neg();
    test_add();
    test_and();
    test_cmp();
    test_mov_reg();
    test_mvn();
    test_illegal();
    test_load_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
